// File: rtl/sst_pkg.sv
// Shared definitions for the save-state sequencer.
//   SST_ADDR_W   : width of the mapper save-state register address
//   SST_IDX_ADDR : sst address at which the mapper returns its map index
//   sst_state_e  : sequencer FSM states
package sst_pkg;

    localparam int SST_ADDR_W = 8;
    localparam int SST_IDX_ADDR = 127;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_S_ADDR,
        ST_S_CAP,
        ST_S_WR,
        ST_R_IDX,
        ST_R_CMP,
        ST_R_RD,
        ST_R_WE,
        ST_R_WH,
        ST_R_NX,
        ST_DONE,
        ST_ERR
    } sst_state_e;

endpackage

// File: rtl/m2_fall_det.sv
// Brings the CPU M2 clock into the clk domain and flags its falling edges.
//   clk      : system clock
//   map_rst  : asynchronous active-high reset
//   m2_i     : CPU M2, asynchronous to clk
//   fall_o   : one-cycle pulse per synchronized M2 falling edge
module m2_fall_det (
    input  logic clk,
    input  logic map_rst,
    input  logic m2_i,
    output logic fall_o
);

    // [0],[1] form the synchronizer; [2] is the previous synchronized level.
    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge map_rst) begin
        if (map_rst) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], m2_i};
        end
    end

    assign fall_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/sst_seq.sv
// Save-state sequencer: initiator on the mapper save-state register bus.
// Save walks every mapper register and stores it in the state buffer;
// restore checks the stored map index against the live mapper and then
// writes every stored byte back, timing each write to an M2 falling edge.
//   clk, map_rst            : clock, async active-high reset
//   start, dir              : request (0 save, 1 restore), sampled in IDLE
//   m2                      : CPU M2 (async)
//   busy, done, err         : status; done/err are one-cycle pulses
//   sst_act, sst_addr,
//   sst_dato, sst_we_reg,
//   sst_di                  : mapper save-state register bus
//   mem_addr, mem_dout,
//   mem_din, mem_we,
//   mem_re, mem_ack         : state buffer request/ack port
//
// state   | meaning
// IDLE    | waiting for start
// S_ADDR  | save: address driven, waiting read latency
// S_CAP   | save: capture sst_di
// S_WR    | save: buffer write until ack
// R_IDX   | restore: read stored map index from buffer
// R_CMP   | restore: compare stored index with live mapper
// R_RD    | restore: read stored byte from buffer
// R_WE    | restore: write strobe, waiting for M2 fall or timeout
// R_WH    | restore: strobe held one cycle past the M2 fall
// R_NX    | restore: strobe low, advance index
// DONE    | done pulse
// ERR     | err pulse
module sst_seq
    import sst_pkg::*;
#(
    parameter int NREGS    = 256,
    parameter int RD_LAT   = 2,
    parameter int IDX_ADDR = SST_IDX_ADDR,
    parameter int M2_TO    = 4096
) (
    input  logic                  clk,
    input  logic                  map_rst,
    input  logic                  start,
    input  logic                  dir,
    input  logic                  m2,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  sst_act,
    output logic [SST_ADDR_W-1:0] sst_addr,
    output logic [7:0]            sst_dato,
    output logic                  sst_we_reg,
    input  logic [7:0]            sst_di,
    output logic [SST_ADDR_W-1:0] mem_addr,
    output logic [7:0]            mem_dout,
    input  logic [7:0]            mem_din,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic                  mem_ack
);

    localparam int TMAX = (M2_TO > RD_LAT) ? M2_TO : RD_LAT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_RD  = TW'(RD_LAT - 1);
    localparam logic [TW-1:0] T_TO  = TW'(M2_TO - 1);
    // A fall seen in the first two strobe cycles may have happened before
    // the strobe rose (synchronizer latency), so it is not accepted.
    localparam logic [TW-1:0] T_ARM = TW'(M2_TO - 3);
    localparam logic [8:0] IDX_LAST = 9'(NREGS - 1);
    localparam logic [8:0] IDX_SKIP = 9'(IDX_ADDR);
    localparam logic [SST_ADDR_W-1:0] IDX_A = SST_ADDR_W'(IDX_ADDR);

    sst_state_e    state_q, state_d;
    logic [8:0]    idx_q, idx_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [7:0]    cmp_q, cmp_d;
    logic [7:0]    dout_q, dout_d;
    logic [7:0]    dato_q, dato_d;
    logic          m2_fall;
    logic          at_idx;

    m2_fall_det u_m2_fall_det (
        .clk     (clk),
        .map_rst (map_rst),
        .m2_i    (m2),
        .fall_o  (m2_fall)
    );

    always_ff @(posedge clk or posedge map_rst) begin
        if (map_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            tmr_q   <= '0;
            cmp_q   <= '0;
            dout_q  <= '0;
            dato_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            cmp_q   <= cmp_d;
            dout_q  <= dout_d;
            dato_q  <= dato_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        cmp_d   = cmp_q;
        dout_d  = dout_q;
        dato_d  = dato_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d = '0;
                    if (dir) begin
                        state_d = ST_R_IDX;
                    end else begin
                        tmr_d   = T_RD;
                        state_d = ST_S_ADDR;
                    end
                end
            end
            ST_S_ADDR: begin
                if (tmr_q == '0) state_d = ST_S_CAP;
                else             tmr_d   = tmr_q - TW'(1);
            end
            ST_S_CAP: begin
                dout_d  = sst_di;
                state_d = ST_S_WR;
            end
            ST_S_WR: begin
                if (mem_ack) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 9'd1;
                        tmr_d   = T_RD;
                        state_d = ST_S_ADDR;
                    end
                end
            end
            ST_R_IDX: begin
                if (mem_ack) begin
                    cmp_d   = mem_din;
                    tmr_d   = T_RD;
                    state_d = ST_R_CMP;
                end
            end
            ST_R_CMP: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TW'(1);
                end else if (cmp_q != sst_di) begin
                    state_d = ST_ERR;
                end else begin
                    idx_d   = '0;
                    state_d = ST_R_RD;
                end
            end
            ST_R_RD: begin
                if (mem_ack) begin
                    dato_d = mem_din;
                    if (idx_q == IDX_SKIP) begin
                        state_d = ST_R_NX;
                    end else begin
                        tmr_d   = T_TO;
                        state_d = ST_R_WE;
                    end
                end
            end
            ST_R_WE: begin
                if (m2_fall && (tmr_q <= T_ARM)) state_d = ST_R_WH;
                else if (tmr_q == '0)            state_d = ST_ERR;
                else                             tmr_d   = tmr_q - TW'(1);
            end
            ST_R_WH: state_d = ST_R_NX;
            ST_R_NX: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 9'd1;
                    state_d = ST_R_RD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The index check phase addresses the map-index register on both buses.
    assign at_idx     = (state_q == ST_R_IDX) || (state_q == ST_R_CMP);
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);
    assign sst_act    = busy;
    assign done       = (state_q == ST_DONE);
    assign err        = (state_q == ST_ERR);
    assign sst_addr   = at_idx ? IDX_A : idx_q[SST_ADDR_W-1:0];
    assign mem_addr   = at_idx ? IDX_A : idx_q[SST_ADDR_W-1:0];
    assign sst_dato   = dato_q;
    assign sst_we_reg = (state_q == ST_R_WE) || (state_q == ST_R_WH);
    assign mem_dout   = dout_q;
    assign mem_we     = (state_q == ST_S_WR);
    assign mem_re     = (state_q == ST_R_IDX) || (state_q == ST_R_RD);

endmodule

// File: tb/tb_sst_seq.sv
module tb_sst_seq;

    localparam int NREGS    = 256;
    localparam int RD_LAT   = 2;
    localparam int IDX_ADDR = 127;
    localparam int M2_TO    = 64;

    logic       clk = 1'b0;
    logic       map_rst = 1'b0;
    logic       start = 1'b0;
    logic       dir = 1'b0;
    logic       m2 = 1'b1;
    logic       busy, done, err, sst_act, sst_we_reg, mem_we, mem_re;
    logic       mem_ack = 1'b0;
    logic [7:0] sst_addr, sst_dato, sst_di, mem_addr, mem_dout;
    logic [7:0] mem_din = 8'h00;

    sst_seq #(.NREGS(NREGS), .RD_LAT(RD_LAT), .IDX_ADDR(IDX_ADDR), .M2_TO(M2_TO)) dut (
        .clk(clk), .map_rst(map_rst), .start(start), .dir(dir), .m2(m2),
        .busy(busy), .done(done), .err(err), .sst_act(sst_act),
        .sst_addr(sst_addr), .sst_dato(sst_dato), .sst_we_reg(sst_we_reg), .sst_di(sst_di),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
        .mem_we(mem_we), .mem_re(mem_re), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Mapper model: register file plus the map-index register.
    logic [7:0] map_regs [0:255];
    logic [7:0] map_idx = 8'h0B;
    assign sst_di = (sst_addr == 8'(IDX_ADDR)) ? map_idx : map_regs[sst_addr];

    // State buffer model: saves land in sav, restores read from rst_img.
    logic [7:0] sav [0:255];
    logic [7:0] rst_img [0:255];
    int lat_cnt = 0, lat_tgt = 1, n_we_hs = 0;

    always @(negedge clk) begin
        if (map_rst) begin
            mem_ack = 1'b0;
            lat_cnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            mem_din = 8'($urandom);
            lat_cnt = 0;
            lat_tgt = $urandom_range(0, 3);
        end else if (mem_we || mem_re) begin
            if (lat_cnt >= lat_tgt) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    sav[mem_addr] = mem_dout;
                    n_we_hs++;
                end else begin
                    mem_din = rst_img[mem_addr];
                end
            end else begin
                lat_cnt++;
            end
        end else if ($urandom_range(0, 9) == 0) begin
            mem_ack = 1'b1;
            mem_din = 8'($urandom);
        end
    end

    // M2: period 12 clk, edges placed between clk edges.
    bit m2_run = 1'b0;
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!m2_run) begin
                m2 = 1'b1;
                ph = 0;
            end else begin
                ph++;
                if (ph == 6) begin
                    m2 = ~m2;
                    ph = 0;
                end
            end
        end
    end

    // Bus monitor.
    int n_done = 0, n_errp = 0, n_viol = 0, n_we_cyc = 0, n_unstable = 0, n_nofall = 0;
    int cyc = 0, err_cyc = 0, we_rise_cyc = 0;
    bit we_prev = 1'b0, mwe_prev = 1'b0, m2_prev = 1'b1, fell_in_we = 1'b0;
    logic [7:0] we_addr = 8'h00, we_dato = 8'h00;
    logic [15:0] wq [$];
    logic [7:0]  mq [$];

    always @(negedge clk) begin
        cyc++;
        if (done) n_done++;
        if (err) begin
            n_errp++;
            err_cyc = cyc;
        end
        if ((mem_we && mem_re) || ((done || err) && (busy || sst_act)) || (sst_act != busy)) n_viol++;
        if (sst_we_reg) n_we_cyc++;
        if (mem_we && !mwe_prev) mq.push_back(mem_addr);
        if (sst_we_reg && !we_prev) begin
            we_rise_cyc = cyc;
            we_addr = sst_addr;
            we_dato = sst_dato;
        end else if (sst_we_reg && (sst_addr != we_addr || sst_dato != we_dato)) begin
            n_unstable++;
        end
        if (sst_we_reg && m2_prev && !m2) fell_in_we = 1'b1;
        if (!sst_we_reg && we_prev) begin
            wq.push_back({we_addr, we_dato});
            if (!fell_in_we) n_nofall++;
            fell_in_we = 1'b0;
        end
        we_prev  = sst_we_reg;
        mwe_prev = mem_we;
        m2_prev  = m2;
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // What the mapper returns for an sst read at address a.
    function automatic logic [7:0] exp_rd(input int a);
        return (a == IDX_ADDR) ? map_idx : map_regs[a];
    endfunction

    task automatic do_start(input bit d);
        @(posedge clk);
        #1;
        start = 1'b1;
        dir   = d;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int base = n_done + n_errp;
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (n_done + n_errp != base) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        chk(tag, 32'(ok), 32'd1);
    endtask

    function automatic int save_bad();
        int bad = 0;
        for (int i = 0; i < NREGS; i++) if (sav[i] !== exp_rd(i)) bad++;
        return bad;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_done, b_err, b_hs, b_wec, b_viol, b_wq, b_mq, b_uns, b_nof, bad, n127;
        bit found;

        for (int i = 0; i < 256; i++) begin
            map_regs[i] = 8'(i) ^ 8'hA5;
            rst_img[i]  = 8'($urandom);
            sav[i]      = 8'($urandom);
        end

        // Reset state.
        #1 map_rst = 1'b1;
        #1;
        chk("reset_ctrl", 32'({busy, done, err, sst_act, sst_we_reg, mem_we, mem_re}), 32'd0);
        chk("reset_data", {sst_addr, sst_dato, mem_addr, mem_dout}, 32'd0);
        repeat (3) @(posedge clk);
        #1 map_rst = 1'b0;

        // Save with sst_di = addr ^ A5.
        b_done = n_done; b_err = n_errp; b_hs = n_we_hs; b_wec = n_we_cyc; b_viol = n_viol;
        do_start(1'b0);
        wait_end("save_end", 6000);
        chk("save_done", 32'(n_done - b_done), 32'd1);
        chk("save_err", 32'(n_errp - b_err), 32'd0);
        chk("save_hs", 32'(n_we_hs - b_hs), 32'(NREGS));
        chk("save_no_we_reg", 32'(n_we_cyc - b_wec), 32'd0);
        chk("save_buf", 32'(save_bad()), 32'd0);
        chk("save_buf0", 32'(sav[0]), 32'hA5);
        chk("save_buf3", 32'(sav[3]), 32'hA6);
        chk("save_busy_after", 32'(busy), 32'd0);
        chk("save_viol", 32'(n_viol - b_viol), 32'd0);

        // Restore with matching index, M2 running.
        map_idx = 8'h0B;
        rst_img[IDX_ADDR] = 8'h0B;
        rst_img[0] = 8'h03;
        m2_run = 1'b1;
        b_done = n_done; b_err = n_errp; b_wq = wq.size(); b_uns = n_unstable; b_nof = n_nofall;
        b_viol = n_viol;
        do_start(1'b1);
        wait_end("rst_end", 20000);
        chk("rst_done", 32'(n_done - b_done), 32'd1);
        chk("rst_err", 32'(n_errp - b_err), 32'd0);
        chk("rst_npulse", 32'(wq.size() - b_wq), 32'(NREGS - 1));
        bad = 0; n127 = 0;
        begin
            int k = b_wq;
            for (int i = 0; i < NREGS; i++) begin
                if (i == IDX_ADDR) continue;
                if (k >= wq.size() || wq[k] !== {8'(i), rst_img[i]}) bad++;
                k++;
            end
            for (int j = b_wq; j < wq.size(); j++) if (wq[j][15:8] == 8'(IDX_ADDR)) n127++;
        end
        chk("rst_writes", 32'(bad), 32'd0);
        chk("rst_no127", 32'(n127), 32'd0);
        if (wq.size() > b_wq) chk("rst_first", 32'(wq[b_wq]), 32'h0003);
        else chk("rst_first", 32'hFFFF_FFFF, 32'h0003);
        chk("rst_stable", 32'(n_unstable - b_uns), 32'd0);
        chk("rst_m2_span", 32'(n_nofall - b_nof), 32'd0);
        chk("rst_viol", 32'(n_viol - b_viol), 32'd0);

        // Restore with index mismatch.
        map_idx = 8'hB9;
        b_done = n_done; b_err = n_errp; b_wec = n_we_cyc; b_viol = n_viol;
        do_start(1'b1);
        wait_end("mis_end", 500);
        chk("mis_err", 32'(n_errp - b_err), 32'd1);
        chk("mis_done", 32'(n_done - b_done), 32'd0);
        chk("mis_no_we_reg", 32'(n_we_cyc - b_wec), 32'd0);
        chk("mis_busy_next", 32'(busy), 32'd0);
        chk("mis_viol", 32'(n_viol - b_viol), 32'd0);

        // Restore with M2 stuck high: timeout.
        map_idx = 8'h0B;
        m2_run = 1'b0;
        repeat (4) @(posedge clk);
        b_done = n_done; b_err = n_errp;
        do_start(1'b1);
        wait_end("to_end", 2000);
        chk("to_err", 32'(n_errp - b_err), 32'd1);
        chk("to_done", 32'(n_done - b_done), 32'd0);
        chk("to_latency", 32'(err_cyc - we_rise_cyc), 32'(M2_TO));
        chk("to_outs", 32'({sst_we_reg, sst_act}), 32'd0);

        // Reset in the middle of a save at idx 2, then a full save.
        for (int i = 0; i < 256; i++) map_regs[i] = 8'($urandom);
        found = 1'b0;
        do_start(1'b0);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (busy && mem_addr == 8'd2) begin
                found = 1'b1;
                break;
            end
        end
        chk("rmid_reach2", 32'(found), 32'd1);
        b_done = n_done; b_err = n_errp;
        map_rst = 1'b1;
        #1;
        chk("rmid_ctrl", 32'({busy, done, err, sst_act, sst_we_reg, mem_we, mem_re}), 32'd0);
        chk("rmid_data", {sst_addr, sst_dato, mem_addr, mem_dout}, 32'd0);
        repeat (3) @(posedge clk);
        #1 map_rst = 1'b0;
        repeat (5) @(posedge clk);
        chk("rmid_no_pulse", 32'((n_done - b_done) + (n_errp - b_err)), 32'd0);
        b_mq = mq.size(); b_hs = n_we_hs; b_done = n_done;
        do_start(1'b0);
        wait_end("rmid_save_end", 6000);
        chk("rmid_first_addr", (mq.size() > b_mq) ? 32'(mq[b_mq]) : 32'hFFFF_FFFF, 32'd0);
        chk("rmid_hs", 32'(n_we_hs - b_hs), 32'(NREGS));
        chk("rmid_buf", 32'(save_bad()), 32'd0);
        chk("rmid_done", 32'(n_done - b_done), 32'd1);

        // start pulses and dir changes while busy.
        for (int i = 0; i < 256; i++) map_regs[i] = 8'($urandom);
        b_done = n_done; b_err = n_errp; b_wec = n_we_cyc;
        do_start(1'b0);
        repeat (20) @(posedge clk);
        do_start(1'b1);
        repeat (30) @(posedge clk);
        do_start(1'b0);
        #1 dir = 1'b1;
        wait_end("busy_end", 6000);
        repeat (40) @(posedge clk);
        #1;
        chk("busy_done", 32'(n_done - b_done), 32'd1);
        chk("busy_err", 32'(n_errp - b_err), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("busy_buf", 32'(save_bad()), 32'd0);
        chk("busy_no_we_reg", 32'(n_we_cyc - b_wec), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_fail);
        $finish;
    end

endmodule
